// File: rtl/s3_pkg.sv
// s3_pkg: shared constants, trit encodings and the state type for the S3 unpacker.
//   N_BYTES        - packed input bytes per polynomial
//   TRITS_PER_BYTE - base-3 digits carried by one packed byte
//   PACK_W/POLY_W  - widths of the packed input and the trit polynomial
//   FIELD_W        - width of the trit field produced from one byte
//   state_t        - unpacker sequencing states
package s3_pkg;

  localparam int N_BYTES        = 140;
  localparam int TRITS_PER_BYTE = 5;
  localparam int PACK_W         = 8 * N_BYTES;
  localparam int POLY_W         = 2 * TRITS_PER_BYTE * N_BYTES;
  localparam int FIELD_W        = 2 * TRITS_PER_BYTE;

  // Largest byte value that encodes five genuine trits (3^5 - 1).
  localparam logic [7:0] MAX_VALID_BYTE = 8'd242;

  localparam logic [1:0] TRIT_0 = 2'b00;
  localparam logic [1:0] TRIT_1 = 2'b01;
  localparam logic [1:0] TRIT_2 = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/unpack_s3_bit8_to_trit5.sv
// bit8_to_trit5: purely combinational decode of one packed byte into five
// base-3 digits.
//   c       - packed byte (value 0..255)
//   trits   - digit k in trits[2k+1:2k], digit k = floor(c/3^k) mod 3
//   invalid - high when c exceeds 242 and so cannot come from a real packer
module bit8_to_trit5
  import s3_pkg::*;
(
  input  logic [7:0]         c,
  output logic [FIELD_W-1:0] trits,
  output logic               invalid
);

  // Successive quotients by 3: q[k] = floor(c / 3^k). Dividing the previous
  // quotient by 3 again gives the same result as dividing c by 3^k directly.
  logic [7:0] q [TRITS_PER_BYTE];

  always_comb begin
    q[0] = c;
    for (int k = 1; k < TRITS_PER_BYTE; k++) begin
      q[k] = q[k-1] / 8'd3;
    end
  end

  // Each digit is the quotient reduced mod 3. Bytes above 242 still follow
  // the same formula, so the top digit wraps deterministically.
  always_comb begin
    trits = '0;
    for (int k = 0; k < TRITS_PER_BYTE; k++) begin
      trits[2*k +: 2] = 2'(q[k] % 8'd3);
    end
  end

  assign invalid = (c > MAX_VALID_BYTE);

endmodule

// File: rtl/unpack_s3.sv
// unpack_s3: iterative S3 unpacker, one packed byte per clock.
//   clk     - clock, rising edge
//   rst     - asynchronous active-high reset
//   start   - one-cycle request, honoured only in IDLE or DONE
//   a       - packed bytes, byte j = a[8j+7:8j]
//   out     - trits, trit i = out[2i+1:2i]; valid while done is high
//   busy    - high while unpacking
//   done    - high once all bytes are decoded, until the next start
//   invalid - sticky: some byte of the current operation exceeded 242
module unpack_s3
  import s3_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PACK_W-1:0] a,
  output logic [POLY_W-1:0] out,
  output logic              busy,
  output logic              done,
  output logic              invalid
);

  state_t            state;
  logic [7:0]        count;
  logic [PACK_W-1:0] reg_in;

  logic [FIELD_W-1:0] byte_trits;
  logic               byte_invalid;

  // The lowest unconsumed byte is always reg_in[7:0]; it moves down by a
  // byte every RUN cycle.
  bit8_to_trit5 u_decode (
    .c       (reg_in[7:0]),
    .trits   (byte_trits),
    .invalid (byte_invalid)
  );

  // Sequencing and datapath. New trit fields enter at the top of out and the
  // whole polynomial shifts right, so after N_BYTES steps byte 0's field has
  // travelled down to bits [9:0]. busy and done are registered alongside the
  // state so they never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      reg_in  <= '0;
      out     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      invalid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= RUN;
            reg_in  <= a;
            count   <= '0;
            out     <= '0;
            invalid <= 1'b0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        RUN: begin
          out     <= {byte_trits, out[POLY_W-1:FIELD_W]};
          reg_in  <= reg_in >> 8;
          invalid <= invalid | byte_invalid;
          count   <= count + 8'd1;
          if (count == 8'(N_BYTES - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unpack_s3.sv
// tb_unpack_s3: self-checking bench for unpack_s3. Table-driven vectors with
// expected results from a behavioural base-3 model, plus hand-written
// sequences for start-while-busy and reset-during-run.
module tb_unpack_s3;

  localparam int NB = 140;
  localparam int NT = 700;
  localparam int NVEC = 10;
  localparam int CYCLE_LIMIT = 1000;

  logic            clk;
  logic            rst;
  logic            start;
  logic [1119:0]   a;
  logic [1399:0]   out;
  logic            busy;
  logic            done;
  logic            invalid;

  int checks;
  int errors;

  typedef struct {
    logic [1119:0] a;
    logic [1399:0] exp_out;
    logic          exp_invalid;
  } vec_t;

  vec_t vecs [NVEC];

  unpack_s3 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .out     (out),
    .busy    (busy),
    .done    (done),
    .invalid (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: trit 5j+k = floor(byte_j / 3^k) mod 3.
  function automatic logic [1399:0] modelUnpack(input logic [1119:0] pa);
    logic [1399:0] r;
    int v;
    r = '0;
    for (int j = 0; j < NB; j++) begin
      v = int'(pa[8*j +: 8]);
      for (int k = 0; k < 5; k++) begin
        r[2*(5*j+k) +: 2] = 2'((v / (3 ** k)) % 3);
      end
    end
    return r;
  endfunction

  function automatic logic modelInvalid(input logic [1119:0] pa);
    logic bad;
    bad = 1'b0;
    for (int j = 0; j < NB; j++) begin
      if (int'(pa[8*j +: 8]) > 242) bad = 1'b1;
    end
    return bad;
  endfunction

  // Packer: byte j = sum_k trit(5j+k) * 3^k.
  function automatic logic [1119:0] packTrits(input logic [1399:0] t);
    logic [1119:0] r;
    int v;
    r = '0;
    for (int j = 0; j < NB; j++) begin
      v = 0;
      for (int k = 0; k < 5; k++) begin
        v = v + int'(t[2*(5*j+k) +: 2]) * (3 ** k);
      end
      r[8*j +: 8] = 8'(v);
    end
    return r;
  endfunction

  function automatic logic [1399:0] randomTrits();
    logic [1399:0] t;
    for (int i = 0; i < NT; i++) t[2*i +: 2] = 2'($urandom_range(0, 2));
    return t;
  endfunction

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [1399:0] act,
                             input logic [1399:0] exp);
    int first;
    checks++;
    if (act !== exp) begin
      errors++;
      first = -1;
      for (int i = NT - 1; i >= 0; i--) begin
        if (act[2*i +: 2] !== exp[2*i +: 2]) first = i;
      end
      $display("[TB] FAIL %s: trit %0d got %0d expected %0d", name, first,
               act[2*first +: 2], exp[2*first +: 2]);
    end
  endtask

  // Pulse start with the given input, then wait for done and report how many
  // sampled cycles busy was high.
  task automatic applyStimulus(input logic [1119:0] pa, output int busy_cycles,
                               output logic timed_out);
    int n;
    @(negedge clk);
    a = pa;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = '0;
    busy_cycles = 0;
    n = 0;
    while (!done && n < CYCLE_LIMIT) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      n++;
    end
    timed_out = !done;
  endtask

  initial begin
    int bc;
    logic to;
    logic [1399:0] t;
    logic [1119:0] pa;
    logic [1399:0] held;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    start = 1'b0;
    a = '0;

    // Fixed vectors with hand-derived expectations.
    vecs[0].a = '0;
    vecs[0].exp_out = '0;
    vecs[0].exp_invalid = 1'b0;

    vecs[1].a = '0;
    vecs[1].a[7:0] = 8'd100;
    vecs[1].exp_out = '0;
    vecs[1].exp_out[9:0] = 10'b01_00_10_00_01;
    vecs[1].exp_invalid = 1'b0;

    vecs[2].a = {140{8'd242}};
    vecs[2].exp_out = {700{2'b10}};
    vecs[2].exp_invalid = 1'b0;

    vecs[3].a = '0;
    vecs[3].a[1119:1112] = 8'd243;
    vecs[3].exp_out = '0;
    vecs[3].exp_invalid = 1'b1;

    // Directly follows the invalid vector: invalid must clear.
    vecs[4].a = '0;
    vecs[4].exp_out = '0;
    vecs[4].exp_invalid = 1'b0;

    // Round trips: random trits packed then unpacked must come back intact.
    for (int v = 5; v < 8; v++) begin
      t = randomTrits();
      vecs[v].a = packTrits(t);
      vecs[v].exp_out = t;
      vecs[v].exp_invalid = 1'b0;
    end

    // Raw random bytes, including out-of-range values.
    for (int v = 8; v < NVEC; v++) begin
      for (int j = 0; j < NB; j++) pa[8*j +: 8] = 8'($urandom_range(0, 255));
      pa[8*17 +: 8] = 8'd255;
      vecs[v].a = pa;
      vecs[v].exp_out = modelUnpack(pa);
      vecs[v].exp_invalid = modelInvalid(pa);
    end

    repeat (3) @(negedge clk);
    checkBit("reset_busy", busy, 1'b0);
    checkBit("reset_done", done, 1'b0);
    checkBit("reset_invalid", invalid, 1'b0);
    checkOutput("reset_out", out, '0);
    rst = 1'b0;

    for (int v = 0; v < NVEC; v++) begin
      applyStimulus(vecs[v].a, bc, to);
      checkBit($sformatf("vec%0d_timeout", v), to, 1'b0);
      checkInt($sformatf("vec%0d_busy_cycles", v), bc, NB);
      checkBit($sformatf("vec%0d_done", v), done, 1'b1);
      checkOutput($sformatf("vec%0d_out", v), out, vecs[v].exp_out);
      checkBit($sformatf("vec%0d_invalid", v), invalid, vecs[v].exp_invalid);
    end

    // done and out hold without a new start.
    held = out;
    repeat (5) @(negedge clk);
    checkBit("hold_done", done, 1'b1);
    checkOutput("hold_out", out, held);

    // Start pulsed mid-run with different data must be ignored.
    t = randomTrits();
    @(negedge clk);
    a = packTrits(t);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = '0;
    bc = 1;
    repeat (49) begin
      @(negedge clk);
      if (busy) bc++;
    end
    a = {140{8'd250}};
    start = 1'b1;
    @(negedge clk);
    if (busy) bc++;
    start = 1'b0;
    a = '0;
    for (int n = 0; n < CYCLE_LIMIT && !done; n++) begin
      @(negedge clk);
      if (busy) bc++;
    end
    checkBit("midstart_done", done, 1'b1);
    checkInt("midstart_busy_cycles", bc, NB);
    checkOutput("midstart_out", out, t);
    checkBit("midstart_invalid", invalid, 1'b0);

    // Reset at RUN cycle 70 aborts and clears everything immediately.
    pa = packTrits(randomTrits());
    pa[7:0] = 8'd243;
    @(negedge clk);
    a = pa;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (69) @(negedge clk);
    checkBit("abort_busy_before", busy, 1'b1);
    checkBit("abort_invalid_before", invalid, 1'b1);
    rst = 1'b1;
    #1;
    checkBit("abort_busy", busy, 1'b0);
    checkBit("abort_done", done, 1'b0);
    checkBit("abort_invalid", invalid, 1'b0);
    checkOutput("abort_out", out, '0);
    @(negedge clk);
    rst = 1'b0;

    t = randomTrits();
    applyStimulus(packTrits(t), bc, to);
    checkBit("fresh_timeout", to, 1'b0);
    checkInt("fresh_busy_cycles", bc, NB);
    checkOutput("fresh_out", out, t);
    checkBit("fresh_invalid", invalid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
